// File: rtl/wb_regfile_stage.sv
// Writeback stage: result select, load extension, 32x32 flop register file
// with write-through read bypass, and a retired-instruction counter.
module wb_regfile_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned CNT_W = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcW,
  input  logic [XLEN-1:0]  ALUResultW,
  input  logic [XLEN-1:0]  ReadDataW,
  input  logic [4:0]       RdW,
  input  logic [XLEN-1:0]  PCPlus4W,
  input  logic [2:0]       LoadFunct3W,
  input  logic             RetireW,
  input  logic [4:0]       A1D,
  input  logic [4:0]       A2D,
  output logic [XLEN-1:0]  RD1D,
  output logic [XLEN-1:0]  RD2D,
  output logic [XLEN-1:0]  ResultW,
  output logic [CNT_W-1:0] InstRetW
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [CNT_W-1:0] r_instret;

  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [XLEN-1:0]  w_load_ext;
  logic [XLEN-1:0]  w_result;
  logic             w_wr_en;

  always_comb begin
    w_byte = ReadDataW[7:0];
    case (ALUResultW[1:0])
      2'd0:    w_byte = ReadDataW[7:0];
      2'd1:    w_byte = ReadDataW[15:8];
      2'd2:    w_byte = ReadDataW[23:16];
      default: w_byte = ReadDataW[31:24];
    endcase
    // Halfword offset bit 0 is ignored; misaligned loads trap upstream.
    w_half = ALUResultW[1] ? ReadDataW[31:16] : ReadDataW[15:0];
  end

  always_comb begin
    w_load_ext = ReadDataW;
    case (LoadFunct3W)
      3'b000:  w_load_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b100:  w_load_ext = {{(XLEN-8){1'b0}}, w_byte};
      3'b001:  w_load_ext = {{(XLEN-16){w_half[15]}}, w_half};
      3'b101:  w_load_ext = {{(XLEN-16){1'b0}}, w_half};
      default: w_load_ext = ReadDataW;
    endcase
  end

  always_comb begin
    w_result = '0;
    case (ResultSrcW)
      2'b00:   w_result = ALUResultW;
      2'b01:   w_result = w_load_ext;
      2'b10:   w_result = PCPlus4W;
      default: w_result = '0;
    endcase
  end

  assign w_wr_en = RegWriteW && (RdW != 5'd0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[RdW] <= w_result;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_instret <= '0;
    else if (RetireW) r_instret <= r_instret + CNT_W'(1);
  end

  // Same-cycle bypass lets D see the value W is writing this cycle.
  always_comb begin
    RD1D = r_regs[A1D];
    if (A1D == 5'd0) RD1D = '0;
    else if (w_wr_en && (RdW == A1D)) RD1D = w_result;
  end

  always_comb begin
    RD2D = r_regs[A2D];
    if (A2D == 5'd0) RD2D = '0;
    else if (w_wr_en && (RdW == A2D)) RD2D = w_result;
  end

  assign ResultW  = w_result;
  assign InstRetW = r_instret;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed self-checking bench for wb_regfile_stage.
module tb_wb_regfile_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        RegWriteW = 1'b0;
  logic [1:0]  ResultSrcW = 2'b00;
  logic [31:0] ALUResultW = '0;
  logic [31:0] ReadDataW = '0;
  logic [4:0]  RdW = '0;
  logic [31:0] PCPlus4W = '0;
  logic [2:0]  LoadFunct3W = '0;
  logic        RetireW = 1'b0;
  logic [4:0]  A1D = '0;
  logic [4:0]  A2D = '0;
  logic [31:0] RD1D, RD2D, ResultW;
  logic [63:0] InstRetW;
  logic [31:0] s_RD1D, s_RD2D, s_ResultW;
  logic [3:0]  s_InstRetW;

  int checks = 0;
  int failures = 0;

  wb_regfile_stage #(.XLEN(32), .NREGS(32), .CNT_W(64)) dut (
    .CLK(CLK), .RST(RST), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .RdW(RdW),
    .PCPlus4W(PCPlus4W), .LoadFunct3W(LoadFunct3W), .RetireW(RetireW),
    .A1D(A1D), .A2D(A2D), .RD1D(RD1D), .RD2D(RD2D), .ResultW(ResultW),
    .InstRetW(InstRetW)
  );

  // Narrow counter instance makes the wrap boundary reachable in a few cycles.
  wb_regfile_stage #(.XLEN(32), .NREGS(32), .CNT_W(4)) dut_s (
    .CLK(CLK), .RST(RST), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .RdW(RdW),
    .PCPlus4W(PCPlus4W), .LoadFunct3W(LoadFunct3W), .RetireW(RetireW),
    .A1D(A1D), .A2D(A2D), .RD1D(s_RD1D), .RD2D(s_RD2D), .ResultW(s_ResultW),
    .InstRetW(s_InstRetW)
  );

  always #5 CLK = ~CLK;

  task automatic idle_inputs();
    RegWriteW = 1'b0; ResultSrcW = 2'b00; ALUResultW = '0; ReadDataW = '0;
    RdW = '0; PCPlus4W = '0; LoadFunct3W = '0; RetireW = 1'b0; A1D = '0; A2D = '0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    idle_inputs();
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 RST = 1'b1;
    #1;
    checks++;
    if (InstRetW !== 64'd0) begin
      failures++; $display("FAIL reset_instret got=%h exp=0", InstRetW);
    end
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 1; i < 32; i++) begin
      @(negedge CLK);
      A1D = 5'(i); A2D = 5'(32 - i);
      #1;
      checks++;
      if (RD1D !== 32'd0 || RD2D !== 32'd0) begin
        failures++;
        $display("FAIL reset_read x%0d got1=%h got2=%h exp=0", i, RD1D, RD2D);
      end
    end
  endtask

  task automatic test_bypass();
    @(negedge CLK);
    RegWriteW = 1'b1; RdW = 5'd5; ResultSrcW = 2'b00; ALUResultW = 32'hDEADBEEF;
    A1D = 5'd5; A2D = 5'd5;
    #1;
    checks++;
    if (RD1D !== 32'hDEADBEEF || RD2D !== 32'hDEADBEEF) begin
      failures++; $display("FAIL bypass_same_cycle got1=%h got2=%h exp=deadbeef", RD1D, RD2D);
    end
    @(negedge CLK);
    RegWriteW = 1'b0; ALUResultW = 32'h0;
    #1;
    checks++;
    if (RD1D !== 32'hDEADBEEF) begin
      failures++; $display("FAIL bypass_after_edge got=%h exp=deadbeef", RD1D);
    end
  endtask

  task automatic test_x0();
    @(negedge CLK);
    RegWriteW = 1'b1; RdW = 5'd0; ResultSrcW = 2'b00; ALUResultW = 32'h1234; A1D = 5'd0;
    #1;
    checks++;
    if (RD1D !== 32'd0) begin
      failures++; $display("FAIL x0_no_bypass got=%h exp=0", RD1D);
    end
    @(negedge CLK);
    RegWriteW = 1'b0; A1D = 5'd0; A2D = 5'd0;
    #1;
    checks++;
    if (RD1D !== 32'd0 || RD2D !== 32'd0) begin
      failures++; $display("FAIL x0_read got1=%h got2=%h exp=0", RD1D, RD2D);
    end
  endtask

  task automatic test_load();
    logic [2:0]  f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b010};
    logic [1:0]  off [6] = '{2'd2, 2'd3, 2'd0, 2'd2, 2'd3, 2'd1};
    logic [31:0] exp [6] = '{32'hFFFFFFF1, 32'h00000080, 32'h00007F01,
                             32'h000080F1, 32'hFFFF80F1, 32'h80F17F01};
    @(negedge CLK);
    idle_inputs();
    ReadDataW = 32'h80F17F01; ResultSrcW = 2'b01;
    for (int i = 0; i < 6; i++) begin
      LoadFunct3W = f3[i]; ALUResultW = {28'h0001000, 2'b00, off[i]};
      #1;
      checks++;
      if (ResultW !== exp[i]) begin
        failures++;
        $display("FAIL load_ext f3=%b off=%0d got=%h exp=%h", f3[i], off[i], ResultW, exp[i]);
      end
    end
    // Extended load result lands in the register file.
    @(negedge CLK);
    LoadFunct3W = 3'b000; ALUResultW = 32'h2; RegWriteW = 1'b1; RdW = 5'd9;
    @(negedge CLK);
    RegWriteW = 1'b0; ResultSrcW = 2'b00; A2D = 5'd9;
    #1;
    checks++;
    if (RD2D !== 32'hFFFFFFF1) begin
      failures++; $display("FAIL load_writeback got=%h exp=fffffff1", RD2D);
    end
  endtask

  task automatic test_pc4_reserved();
    @(negedge CLK);
    idle_inputs();
    ResultSrcW = 2'b10; PCPlus4W = 32'h104; ALUResultW = 32'h55; RdW = 5'd1; RegWriteW = 1'b1;
    @(negedge CLK);
    RegWriteW = 1'b0; A1D = 5'd1;
    #1;
    checks++;
    if (RD1D !== 32'h104) begin
      failures++; $display("FAIL pc4_write got=%h exp=104", RD1D);
    end
    ResultSrcW = 2'b11; ALUResultW = 32'hFFFFFFFF; ReadDataW = 32'hFFFFFFFF;
    #1;
    checks++;
    if (ResultW !== 32'd0) begin
      failures++; $display("FAIL reserved_src got=%h exp=0", ResultW);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i < 32; i++) begin
      @(negedge CLK);
      idle_inputs();
      RegWriteW = 1'b1; RdW = 5'(i); ALUResultW = 32'hA5000000 | 32'(i * 3);
    end
    @(negedge CLK);
    RegWriteW = 1'b0;
    for (int i = 1; i < 32; i++) begin
      A1D = 5'(i); A2D = 5'(32 - i);
      #1;
      checks++;
      if (RD1D !== (32'hA5000000 | 32'(i * 3)) || RD2D !== (32'hA5000000 | 32'((32 - i) * 3))) begin
        failures++;
        $display("FAIL b2b_read i=%0d got1=%h got2=%h exp1=%h exp2=%h", i, RD1D, RD2D,
                 32'hA5000000 | 32'(i * 3), 32'hA5000000 | 32'((32 - i) * 3));
      end
    end
  endtask

  task automatic test_retire();
    do_reset();
    for (int i = 0; i < 13; i++) begin
      @(negedge CLK);
      RetireW = (i < 5 || i >= 8);
    end
    @(negedge CLK);
    RetireW = 1'b0;
    #1;
    checks++;
    if (InstRetW !== 64'd10) begin
      failures++; $display("FAIL retire_count got=%0d exp=10", InstRetW);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    RetireW = 1'b1;
    repeat (15) @(negedge CLK);
    RetireW = 1'b0;
    #1;
    checks++;
    if (s_InstRetW !== 4'hF || InstRetW !== 64'd15) begin
      failures++; $display("FAIL wrap_max got=%h/%0d exp=f/15", s_InstRetW, InstRetW);
    end
    @(negedge CLK);
    RetireW = 1'b1;
    @(negedge CLK);
    RetireW = 1'b0;
    #1;
    checks++;
    if (s_InstRetW !== 4'h0 || InstRetW !== 64'd16) begin
      failures++; $display("FAIL wrap_zero got=%h/%0d exp=0/16", s_InstRetW, InstRetW);
    end
    A1D = 5'd3; A2D = 5'd0; ResultSrcW = 2'b11;
    #1;
    checks++;
    if (s_RD1D !== 32'd0 || s_RD2D !== 32'd0 || s_ResultW !== 32'd0) begin
      failures++; $display("FAIL small_inst_outputs got=%h %h %h exp=0", s_RD1D, s_RD2D, s_ResultW);
    end
  endtask

  task automatic test_async_reset();
    @(negedge CLK);
    idle_inputs();
    RegWriteW = 1'b1; RdW = 5'd7; ALUResultW = 32'h77; RetireW = 1'b1;
    @(negedge CLK);
    RdW = 5'd8; ALUResultW = 32'h88; A1D = 5'd7; A2D = 5'd9;
    #1;
    checks++;
    if (RD1D !== 32'h77 || InstRetW === 64'd0) begin
      failures++; $display("FAIL pre_reset got=%h cnt=%0d exp=77 cnt!=0", RD1D, InstRetW);
    end
    #1 RST = 1'b1;
    #1;
    checks++;
    if (RD1D !== 32'd0 || RD2D !== 32'd0 || InstRetW !== 64'd0) begin
      failures++;
      $display("FAIL async_clear got1=%h got2=%h cnt=%0d exp=0", RD1D, RD2D, InstRetW);
    end
    @(negedge CLK);
    RST = 1'b0; RegWriteW = 1'b0; RetireW = 1'b0; A1D = 5'd8;
    #1;
    checks++;
    if (RD1D !== 32'd0) begin
      failures++; $display("FAIL pending_write_lost got=%h exp=0", RD1D);
    end
    RegWriteW = 1'b1; RdW = 5'd8; ALUResultW = 32'h1888;
    @(negedge CLK);
    RegWriteW = 1'b0;
    #1;
    checks++;
    if (RD1D !== 32'h1888) begin
      failures++; $display("FAIL resume_after_reset got=%h exp=1888", RD1D);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_x0();
    test_load();
    test_pc4_reserved();
    test_back_to_back();
    test_retire();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
